// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the video-RAM arbiter: FSM state encoding,
// default RAM geometry and the worst-case video fetch latency.
package vram_arb_pkg;

    localparam int DEF_ADDR_W  = 9;
    localparam int DEF_DATA_W  = 16;
    localparam int VID_MAX_LAT = 6;

    typedef enum logic [2:0] {
        IDLE,
        VID_ADDR,
        VID_DATA,
        CPU_ADDR,
        CPU_DATA,
        CPU_WR
    } arb_state_t;

endpackage

// File: rtl/vram_fetch_latch.sv
// Holds a video fetch that arrives while the RAM port is busy, and flags an
// overrun when a second fetch lands before the first was served.
module vram_fetch_latch
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk50,
    input  logic              rst_n,
    input  logic              vid_fetch,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic              busy,
    output logic              vid_pend,
    output logic [ADDR_W-1:0] vid_pend_addr,
    output logic              vid_overrun
);

    // In IDLE the arbiter always serves video, so any pending fetch is consumed;
    // a fresh fetch in that same cycle supersedes it and counts as an overrun.
    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            vid_pend      <= 1'b0;
            vid_pend_addr <= '0;
            vid_overrun   <= 1'b0;
        end else begin
            if (vid_fetch && vid_pend)
                vid_overrun <= 1'b1;
            if (vid_fetch && busy) begin
                vid_pend      <= 1'b1;
                vid_pend_addr <= vid_addr;
            end else if (!busy) begin
                vid_pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Shares one single-port video RAM between scan-out fetches (absolute priority)
// and a req/ack CPU port. All RAM-side and handshake outputs are registered.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk50,
    input  logic              rst_n,
    input  logic              vid_fetch,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_overrun,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_rdata
);

    arb_state_t        state, state_nxt;
    logic [ADDR_W-1:0] ram_addr_nxt;
    logic [DATA_W-1:0] ram_wdata_nxt, vid_data_nxt, cpu_rdata_nxt;
    logic              ram_load_nxt, vid_valid_nxt, cpu_ack_nxt;
    logic              vid_pend;
    logic [ADDR_W-1:0] vid_pend_addr;
    logic              busy;

    assign busy = (state != IDLE);

    vram_fetch_latch #(.ADDR_W(ADDR_W)) u_fetch_latch (
        .clk50        (clk50),
        .rst_n        (rst_n),
        .vid_fetch    (vid_fetch),
        .vid_addr     (vid_addr),
        .busy         (busy),
        .vid_pend     (vid_pend),
        .vid_pend_addr(vid_pend_addr),
        .vid_overrun  (vid_overrun)
    );

    always_comb begin
        // NOTE: every output of this block gets a default before the case, so no path can infer a latch.
        state_nxt     = state;
        ram_addr_nxt  = ram_addr;
        ram_wdata_nxt = ram_wdata;
        ram_load_nxt  = 1'b0;
        vid_data_nxt  = vid_data;
        vid_valid_nxt = 1'b0;
        cpu_rdata_nxt = cpu_rdata;
        cpu_ack_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (vid_fetch || vid_pend) begin
                    ram_addr_nxt = vid_fetch ? vid_addr : vid_pend_addr;
                    state_nxt    = VID_ADDR;
                end else if (cpu_req && !cpu_ack) begin
                    // A request still high during its own ack cycle is the old one.
                    ram_addr_nxt = cpu_addr;
                    if (cpu_we) begin
                        ram_wdata_nxt = cpu_wdata;
                        ram_load_nxt  = 1'b1;
                        state_nxt     = CPU_WR;
                    end else begin
                        state_nxt = CPU_ADDR;
                    end
                end
            end
            VID_ADDR: state_nxt = VID_DATA;
            VID_DATA: begin
                vid_data_nxt  = ram_rdata;
                vid_valid_nxt = 1'b1;
                state_nxt     = IDLE;
            end
            CPU_ADDR: state_nxt = CPU_DATA;
            CPU_DATA: begin
                cpu_rdata_nxt = ram_rdata;
                cpu_ack_nxt   = 1'b1;
                state_nxt     = IDLE;
            end
            CPU_WR: begin
                cpu_ack_nxt = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Clearing ram_load in reset guarantees an interrupted write is never replayed.
    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            state     <= IDLE;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_load  <= 1'b0;
            vid_data  <= '0;
            vid_valid <= 1'b0;
            cpu_rdata <= '0;
            cpu_ack   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so each register updates from pre-edge values regardless of order.
            state     <= state_nxt;
            ram_addr  <= ram_addr_nxt;
            ram_wdata <= ram_wdata_nxt;
            ram_load  <= ram_load_nxt;
            vid_data  <= vid_data_nxt;
            vid_valid <= vid_valid_nxt;
            cpu_rdata <= cpu_rdata_nxt;
            cpu_ack   <= cpu_ack_nxt;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: a table of single transactions from IDLE,
// then hand-written reset, collision, overrun and back-to-back sequences.
module tb_vram_arbiter;
    import vram_arb_pkg::*;

    localparam int AW = 9;
    localparam int DW = 16;

    logic          clk50 = 1'b0;
    logic          rst_n;
    logic          vid_fetch;
    logic [AW-1:0] vid_addr;
    logic          vid_valid;
    logic [DW-1:0] vid_data;
    logic          vid_overrun;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_load;
    logic [DW-1:0] ram_rdata;

    always #5 clk50 = ~clk50;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk50      (clk50),
        .rst_n      (rst_n),
        .vid_fetch  (vid_fetch),
        .vid_addr   (vid_addr),
        .vid_valid  (vid_valid),
        .vid_data   (vid_data),
        .vid_overrun(vid_overrun),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_load   (ram_load),
        .ram_rdata  (ram_rdata)
    );

    // NOTE: the RAM array is never reset; contents are preloaded once, as a real BRAM's would be.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk50) begin
        if (ram_load) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef enum logic [1:0] {K_VID, K_RD, K_WR} kind_t;
    typedef struct {
        kind_t         kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_data;
        int            exp_lat;
    } vec_t;

    // Issues one transaction from IDLE at a negedge and waits (bounded) for its completion pulse.
    task automatic run_vec(input vec_t v, input int idx);
        int            lat;
        int            loads;
        logic [DW-1:0] got;
        lat   = -1;
        loads = 0;
        got   = '0;
        if (v.kind == K_VID) begin
            vid_fetch = 1'b1;
            vid_addr  = v.addr;
        end else begin
            cpu_req   = 1'b1;
            cpu_we    = (v.kind == K_WR);
            cpu_addr  = v.addr;
            cpu_wdata = v.wdata;
        end
        for (int k = 1; k <= 12 && lat < 0; k++) begin
            @(negedge clk50);
            vid_fetch = 1'b0;
            loads += int'(ram_load);
            if (v.kind == K_VID && vid_valid) begin
                lat = k;
                got = vid_data;
            end
            if (v.kind != K_VID && cpu_ack) begin
                lat = k;
                got = cpu_rdata;
                cpu_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        check($sformatf("vec%0d latency", idx), lat, v.exp_lat);
        if (v.kind != K_WR)
            check($sformatf("vec%0d data", idx), {16'h0, got}, {16'h0, v.exp_data});
        check($sformatf("vec%0d ram_load pulses", idx), loads, (v.kind == K_WR) ? 1 : 0);
    endtask

    vec_t vecs [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            vlat, clat, n, last, pulses, loads;
        logic [DW-1:0] vd, cd;

        vecs[0] = '{K_VID, 9'h0EF, 16'h0000, 16'h0005, 3};
        vecs[1] = '{K_WR,  9'h1FF, 16'hA5C3, 16'h0000, 2};
        vecs[2] = '{K_RD,  9'h1FF, 16'h0000, 16'hA5C3, 3};
        vecs[3] = '{K_VID, 9'h1FF, 16'h0000, 16'hA5C3, 3};
        vecs[4] = '{K_RD,  9'h010, 16'h0000, 16'h1010, 3};
        vecs[5] = '{K_WR,  9'h030, 16'h7E81, 16'h0000, 2};
        vecs[6] = '{K_VID, 9'h030, 16'h0000, 16'h7E81, 3};

        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h1000 + 16'(i);
        mem[9'h0EF] = 16'h0005;

        // Reset held with a pending CPU read and toggling fetches: everything stays 0.
        rst_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h0EF; cpu_wdata = '0;
        vid_fetch = 1'b1; vid_addr = 9'h022;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk50);
            check($sformatf("reset outputs zero c%0d", i),
                  {31'h0, |{vid_valid, vid_data, vid_overrun, cpu_ack, cpu_rdata,
                            ram_addr, ram_wdata, ram_load}}, 32'h0);
            vid_fetch = ~vid_fetch;
        end
        vid_fetch = 1'b0;
        rst_n = 1'b1;
        clat = -1; loads = 0; cd = '0;
        for (int k = 1; k <= 10 && clat < 0; k++) begin
            @(negedge clk50);
            loads += int'(ram_load);
            if (cpu_ack) begin clat = k; cd = cpu_rdata; cpu_req = 1'b0; end
        end
        cpu_req = 1'b0;
        check("post-reset read latency", clat, 3);
        check("post-reset read data", {16'h0, cd}, 32'h0005);
        check("post-reset no write", loads, 0);

        for (int i = 0; i < 7; i++) begin
            @(negedge clk50);
            run_vec(vecs[i], i);
        end

        // Collision in IDLE: video served first, CPU read granted afterwards.
        @(negedge clk50);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h010;
        vid_fetch = 1'b1; vid_addr = 9'h020;
        vlat = -1; clat = -1; vd = '0; cd = '0;
        for (int k = 1; k <= 14 && clat < 0; k++) begin
            @(negedge clk50);
            vid_fetch = 1'b0;
            if (vid_valid && vlat < 0) begin vlat = k; vd = vid_data; end
            if (cpu_ack) begin clat = k; cd = cpu_rdata; cpu_req = 1'b0; end
        end
        cpu_req = 1'b0;
        check("collision vid latency", vlat, 3);
        check("collision vid data", {16'h0, vd}, 32'h1020);
        check("collision cpu latency", clat, 6);
        check("collision cpu data", {16'h0, cd}, 32'h1010);

        // Fetch arriving one cycle into a CPU read: bounded latency, no overrun.
        @(negedge clk50);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h001;
        vlat = -1; clat = -1; vd = '0; cd = '0;
        for (int k = 1; k <= 14 && (vlat < 0 || clat < 0); k++) begin
            @(negedge clk50);
            if (vid_valid && vlat < 0) begin vlat = k - 1; vd = vid_data; end
            if (cpu_ack) begin clat = k; cd = cpu_rdata; cpu_req = 1'b0; end
            vid_fetch = (k == 1);
            vid_addr  = 9'h002;
        end
        vid_fetch = 1'b0; cpu_req = 1'b0;
        check("busy fetch within max latency", {31'h0, (vlat > 0 && vlat <= VID_MAX_LAT)}, 32'h1);
        check("busy fetch data", {16'h0, vd}, 32'h1002);
        check("busy fetch cpu latency", clat, 3);
        check("busy fetch cpu data", {16'h0, cd}, 32'h1001);
        check("no overrun yet", {31'h0, vid_overrun}, 32'h0);

        // Two fetches during one CPU read: second overwrites the first, overrun sticks.
        @(negedge clk50);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h003;
        pulses = 0; vd = '0; cd = '0; clat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk50);
            if (vid_valid) begin pulses++; vd = vid_data; end
            if (cpu_ack) begin clat = k; cd = cpu_rdata; cpu_req = 1'b0; end
            vid_fetch = (k == 1 || k == 2);
            vid_addr  = (k == 1) ? 9'h001 : 9'h002;
        end
        vid_fetch = 1'b0; cpu_req = 1'b0;
        check("overrun vid_valid count", pulses, 1);
        check("overrun vid data", {16'h0, vd}, 32'h1002);
        check("overrun flag", {31'h0, vid_overrun}, 32'h1);
        check("overrun cpu latency", clat, 3);
        check("overrun cpu data", {16'h0, cd}, 32'h1003);

        // Back-to-back writes with cpu_req held: one ack every 3 cycles.
        @(negedge clk50);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h000; cpu_wdata = 16'hC000;
        n = 0; last = 0;
        for (int k = 1; k <= 20 && n < 4; k++) begin
            @(negedge clk50);
            if (cpu_ack) begin
                check($sformatf("b2b ack %0d spacing", n), k - last, (n == 0) ? 2 : 3);
                last = k;
                n++;
                if (n < 4) begin
                    cpu_addr  = AW'(n);
                    cpu_wdata = 16'hC000 + 16'(n);
                end else begin
                    cpu_req = 1'b0;
                end
            end
        end
        cpu_req = 1'b0;
        check("b2b ack count", n, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("b2b mem[%0d]", i), {16'h0, mem[i]}, {16'h0, 16'hC000 + 16'(i)});
        check("overrun persists", {31'h0, vid_overrun}, 32'h1);

        // Reset during a write: no ack, no replay, overrun cleared.
        @(negedge clk50);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h100; cpu_wdata = 16'hBEEF;
        @(negedge clk50);
        check("mid-reset write strobe", {31'h0, ram_load}, 32'h1);
        rst_n = 1'b0; cpu_req = 1'b0;
        @(negedge clk50);
        check("mid-reset outputs zero",
              {31'h0, |{vid_valid, vid_data, vid_overrun, cpu_ack, cpu_rdata,
                        ram_addr, ram_wdata, ram_load}}, 32'h0);
        rst_n = 1'b1;
        loads = 0; n = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk50);
            loads += int'(ram_load);
            n     += int'(cpu_ack);
        end
        check("mid-reset no replayed write", loads, 0);
        check("mid-reset no ack", n, 0);
        check("mid-reset overrun cleared", {31'h0, vid_overrun}, 32'h0);
        check("mid-reset single write landed", {16'h0, mem[9'h100]}, 32'hBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
